// File: rtl/axil_reg_pkg.sv
// Shared response codes and FSM state type
// for the AXI-lite register responder.
package axil_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } reg_state_t;

endpackage

// File: rtl/axil_reg_timeout.sv
// Access timeout counter: counts unstalled request
// cycles and flags the cycle that reaches the limit.
module axil_reg_timeout #(
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic hold,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          step;

  assign step = run && !hold;
  // Flag combinationally so the request ends on
  // the TIMEOUT-th counted cycle, not one later.
  assign expired = step && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (step && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axil_reg_responder.sv
// AXI-lite slave bridging AW/W/B and AR/R traffic
// onto a simple request/ack register port.
module axil_reg_responder
  import axil_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_wait,
  input  logic                  reg_wr_ack,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);

  reg_state_t wr_state;
  reg_state_t rd_state;

  logic aw_done;
  logic w_done;
  logic aw_hs;
  logic w_hs;
  logic aw_got;
  logic w_got;
  logic ar_hs;
  logic wr_expired;
  logic rd_expired;

  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot,
                       s_axil_arprot,
                       s_axil_awaddr[ADDR_LSB-1:0],
                       s_axil_araddr[ADDR_LSB-1:0]};

  assign aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_hs   = s_axil_wvalid && s_axil_wready;
  assign aw_got = aw_done || aw_hs;
  assign w_got  = w_done || w_hs;
  assign ar_hs  = s_axil_arvalid && s_axil_arready;

  axil_reg_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_wr_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (wr_state != ST_REQ),
    .run     (reg_wr_en),
    .hold    (reg_wr_wait),
    .expired (wr_expired)
  );

  axil_reg_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_rd_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (rd_state != ST_REQ),
    .run     (reg_rd_en),
    .hold    (reg_rd_wait),
    .expired (rd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state       <= ST_IDLE;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      reg_wr_en      <= 1'b0;
      reg_wr_addr    <= '0;
      reg_wr_data    <= '0;
      reg_wr_strb    <= '0;
    end else begin
      unique case (wr_state)
        ST_IDLE: begin
          if (aw_hs) begin
            reg_wr_addr <= {s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB],
                            {ADDR_LSB{1'b0}}};
          end
          if (w_hs) begin
            reg_wr_data <= s_axil_wdata;
            reg_wr_strb <= s_axil_wstrb;
          end
          s_axil_awready <= !aw_got;
          s_axil_wready  <= !w_got;
          aw_done        <= aw_got;
          w_done         <= w_got;
          if (aw_got && w_got) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            reg_wr_en <= 1'b1;
            wr_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (reg_wr_ack || wr_expired) begin
            reg_wr_en     <= 1'b0;
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= reg_wr_ack ? RESP_OKAY
                                        : RESP_SLVERR;
            wr_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid  <= 1'b0;
            s_axil_awready <= 1'b1;
            s_axil_wready  <= 1'b1;
            wr_state       <= ST_IDLE;
          end
        end
        default: begin
          wr_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state       <= ST_IDLE;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= RESP_OKAY;
      s_axil_rdata   <= '0;
      reg_rd_en      <= 1'b0;
      reg_rd_addr    <= '0;
    end else begin
      unique case (rd_state)
        ST_IDLE: begin
          s_axil_arready <= !ar_hs;
          if (ar_hs) begin
            reg_rd_addr <= {s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB],
                            {ADDR_LSB{1'b0}}};
            reg_rd_en   <= 1'b1;
            rd_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (reg_rd_ack) begin
            reg_rd_en     <= 1'b0;
            s_axil_rvalid <= 1'b1;
            s_axil_rresp  <= RESP_OKAY;
            s_axil_rdata  <= reg_rd_data;
            rd_state      <= ST_RESP;
          end else if (rd_expired) begin
            reg_rd_en     <= 1'b0;
            s_axil_rvalid <= 1'b1;
            s_axil_rresp  <= RESP_SLVERR;
            s_axil_rdata  <= '0;
            rd_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (s_axil_rready) begin
            s_axil_rvalid  <= 1'b0;
            s_axil_arready <= 1'b1;
            rd_state       <= ST_IDLE;
          end
        end
        default: begin
          rd_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_responder.sv
// Randomized scoreboard bench for axil_reg_responder
// with a behavioural register-block model.
module tb_axil_reg_responder;
  import axil_reg_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_axil_awaddr = '0;
  logic [2:0]  s_axil_awprot = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [15:0] s_axil_araddr = '0;
  logic [2:0]  s_axil_arprot = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [15:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en;
  logic        reg_wr_wait = 1'b0;
  logic        reg_wr_ack = 1'b0;
  logic [15:0] reg_rd_addr;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data = '0;
  logic        reg_rd_wait = 1'b0;
  logic        reg_rd_ack = 1'b0;

  always #5 clk = ~clk;

  axil_reg_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16),
    .STRB_WIDTH (4),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awprot  (s_axil_awprot),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arprot  (s_axil_arprot),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .reg_wr_addr    (reg_wr_addr),
    .reg_wr_data    (reg_wr_data),
    .reg_wr_strb    (reg_wr_strb),
    .reg_wr_en      (reg_wr_en),
    .reg_wr_wait    (reg_wr_wait),
    .reg_wr_ack     (reg_wr_ack),
    .reg_rd_addr    (reg_rd_addr),
    .reg_rd_en      (reg_rd_en),
    .reg_rd_data    (reg_rd_data),
    .reg_rd_wait    (reg_rd_wait),
    .reg_rd_ack     (reg_rd_ack)
  );

  // d: en-cycle index of the ack; w: leading wait cycles
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          d;
    int          w;
    bit          noack;
  } plan_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          len;
  } exp_t;

  plan_t wr_plan_q[$];
  plan_t rd_plan_q[$];
  exp_t  wr_exp_q[$];
  exp_t  rd_exp_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int b_hold = 0;
  int r_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h",
                  name, act, req);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: got no event required one", name);
  endtask

  // Ack wins if it lands before TO unstalled cycles pass.
  function automatic exp_t model(input plan_t p);
    exp_t e;
    if (!p.noack && (p.d - p.w) < TO) begin
      e.resp = 2'b00;
      e.data = p.data;
      e.len  = p.d + 1;
    end else begin
      e.resp = 2'b10;
      e.data = 32'h0;
      e.len  = p.w + TO;
    end
    return e;
  endfunction

  // Register-block model, write side
  plan_t wp;
  exp_t  we;
  int    widx = 0;
  bit    wact = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      wact = 0;
      reg_wr_ack = 1'b0;
      reg_wr_wait = 1'b0;
    end else if (reg_wr_en) begin
      if (!wact) begin
        if (wr_plan_q.size() == 0) begin
          fail("wr_en_unexpected");
          wp = '{16'h0, 32'h0, 4'h0, 0, 0, 1'b1};
        end else begin
          wp = wr_plan_q.pop_front();
        end
        chk("wr_addr", reg_wr_addr, wp.addr & 16'hFFFC);
        chk("wr_data", reg_wr_data, wp.data);
        chk("wr_strb", reg_wr_strb, wp.strb);
        wact = 1;
        widx = 0;
      end else begin
        widx++;
      end
      reg_wr_wait = (widx < wp.w);
      reg_wr_ack = !wp.noack && (widx == wp.d);
    end else begin
      if (wact) begin
        we = model(wp);
        chk("wr_en_len", widx + 1, we.len);
        wact = 0;
      end
      reg_wr_ack = ($urandom_range(0, 7) == 0);
      reg_wr_wait = 1'($urandom);
    end
  end

  // Register-block model, read side
  plan_t rp;
  exp_t  re;
  int    ridx = 0;
  bit    ract = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      ract = 0;
      reg_rd_ack = 1'b0;
      reg_rd_wait = 1'b0;
    end else if (reg_rd_en) begin
      if (!ract) begin
        if (rd_plan_q.size() == 0) begin
          fail("rd_en_unexpected");
          rp = '{16'h0, 32'h0, 4'h0, 0, 0, 1'b1};
        end else begin
          rp = rd_plan_q.pop_front();
        end
        chk("rd_addr", reg_rd_addr, rp.addr & 16'hFFFC);
        ract = 1;
        ridx = 0;
      end else begin
        ridx++;
      end
      reg_rd_wait = (ridx < rp.w);
      reg_rd_ack = !rp.noack && (ridx == rp.d);
      reg_rd_data = reg_rd_ack ? rp.data : $urandom;
    end else begin
      if (ract) begin
        re = model(rp);
        chk("rd_en_len", ridx + 1, re.len);
        ract = 0;
      end
      reg_rd_ack = ($urandom_range(0, 7) == 0);
      reg_rd_wait = 1'($urandom);
      reg_rd_data = $urandom;
    end
  end

  int bcnt = 0;
  int rcnt = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rst || !s_axil_bvalid) begin
      bcnt = 0;
      s_axil_bready = 1'b0;
    end else begin
      bcnt++;
      s_axil_bready = (bcnt > b_hold);
    end
    if (rst || !s_axil_rvalid) begin
      rcnt = 0;
      s_axil_rready = 1'b0;
    end else begin
      rcnt++;
      s_axil_rready = (rcnt > r_hold);
    end
  end

  // Write response monitor
  int          aw_c = -1;
  int          w_c = -1;
  int          whs_c = 0;
  int          brise_c = 0;
  bit          bpv = 0;
  bit          bpr = 0;
  logic [1:0]  bpresp = '0;
  exp_t        be;
  always @(negedge clk) begin
    if (rst) begin
      aw_c = -1;
      w_c = -1;
      bpv = 0;
      bpr = 0;
    end else begin
      if (s_axil_awvalid && s_axil_awready) aw_c = cyc;
      if (s_axil_wvalid && s_axil_wready) w_c = cyc;
      if (aw_c >= 0 && w_c >= 0) begin
        whs_c = (aw_c > w_c) ? aw_c : w_c;
        aw_c = -1;
        w_c = -1;
      end
      if (s_axil_bvalid && !bpv) brise_c = cyc;
      if (bpv && !bpr) begin
        chk("b_stall_valid", s_axil_bvalid, 1);
        chk("b_stall_resp", s_axil_bresp, bpresp);
        chk("b_stall_ready",
            {s_axil_awready, s_axil_wready}, 0);
      end
      if (s_axil_bvalid && s_axil_bready) begin
        if (wr_exp_q.size() == 0) begin
          fail("b_unexpected");
        end else begin
          be = wr_exp_q.pop_front();
          chk("bresp", s_axil_bresp, be.resp);
          chk("b_latency", brise_c - whs_c, 1 + be.len);
        end
      end
      bpv = s_axil_bvalid;
      bpr = s_axil_bready;
      bpresp = s_axil_bresp;
    end
  end

  // Read response monitor
  int          ar_c = 0;
  int          rrise_c = 0;
  bit          rpv = 0;
  bit          rpr = 0;
  logic [1:0]  rpresp = '0;
  logic [31:0] rpdata = '0;
  exp_t        ee;
  always @(negedge clk) begin
    if (rst) begin
      rpv = 0;
      rpr = 0;
    end else begin
      if (s_axil_arvalid && s_axil_arready) ar_c = cyc;
      if (s_axil_rvalid && !rpv) rrise_c = cyc;
      if (rpv && !rpr) begin
        chk("r_stall_valid", s_axil_rvalid, 1);
        chk("r_stall_resp", s_axil_rresp, rpresp);
        chk("r_stall_data", s_axil_rdata, rpdata);
        chk("r_stall_ready", s_axil_arready, 0);
      end
      if (s_axil_rvalid && s_axil_rready) begin
        if (rd_exp_q.size() == 0) begin
          fail("r_unexpected");
        end else begin
          ee = rd_exp_q.pop_front();
          chk("rresp", s_axil_rresp, ee.resp);
          chk("rdata", s_axil_rdata, ee.data);
          chk("r_latency", rrise_c - ar_c, 1 + ee.len);
        end
      end
      rpv = s_axil_rvalid;
      rpr = s_axil_rready;
      rpresp = s_axil_rresp;
      rpdata = s_axil_rdata;
    end
  end

  task automatic send_aw(input logic [15:0] a,
                         input int dly);
    bit ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    s_axil_awaddr = a;
    s_axil_awprot = 3'($urandom);
    s_axil_awvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_axil_awready;
    end
    if (!ok) fail("aw_handshake");
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] dt,
                        input logic [3:0] sb,
                        input int dly,
                        input bit w_first);
    bit ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    s_axil_wdata = dt;
    s_axil_wstrb = sb;
    s_axil_wvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_axil_wready;
    end
    if (!ok) fail("w_handshake");
    @(posedge clk); #1;
    s_axil_wvalid = 1'b0;
    if (w_first) begin
      @(negedge clk);
      chk("wready_after_w", s_axil_wready, 0);
    end
  endtask

  // order: 0 same cycle, 1 W leads, 2 AW leads
  task automatic issue_write(input logic [15:0] a,
                             input logic [31:0] dt,
                             input logic [3:0] sb,
                             input int order,
                             input int gap,
                             input int d,
                             input int w,
                             input bit noack);
    plan_t p;
    p = '{a, dt, sb, d, w, noack};
    wr_plan_q.push_back(p);
    wr_exp_q.push_back(model(p));
    fork
      send_aw(a, (order == 1) ? gap : 0);
      send_w(dt, sb, (order == 2) ? gap : 0,
             order == 1);
    join
  endtask

  task automatic issue_read(input logic [15:0] a,
                            input logic [31:0] dt,
                            input int d,
                            input int w,
                            input bit noack);
    plan_t p;
    bit ok = 0;
    p = '{a, dt, 4'h0, d, w, noack};
    rd_plan_q.push_back(p);
    rd_exp_q.push_back(model(p));
    s_axil_araddr = a;
    s_axil_arprot = 3'($urandom);
    s_axil_arvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_axil_arready;
    end
    if (!ok) fail("ar_handshake");
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
  endtask

  task automatic wait_done(input bit is_wr);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((is_wr ? wr_exp_q.size()
                      : rd_exp_q.size()) != 0 && n < 1000);
    #1;
    if ((is_wr ? wr_exp_q.size() : rd_exp_q.size()) != 0)
      fail(is_wr ? "b_response_bound" : "r_response_bound");
  endtask

  task automatic rand_write();
    b_hold = $urandom_range(0, 3);
    issue_write(16'($urandom), $urandom, 4'($urandom),
                $urandom_range(0, 2), $urandom_range(1, 3),
                $urandom_range(0, 6), $urandom_range(0, 3),
                $urandom_range(0, 5) == 0);
    wait_done(1);
  endtask

  task automatic rand_read();
    r_hold = $urandom_range(0, 3);
    issue_read(16'($urandom), $urandom,
               $urandom_range(0, 6), $urandom_range(0, 3),
               $urandom_range(0, 5) == 0);
    wait_done(0);
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",
        {s_axil_awready, s_axil_wready, s_axil_arready}, 0);
    chk("rst_valid", {s_axil_bvalid, s_axil_rvalid}, 0);
    chk("rst_en", {reg_wr_en, reg_rd_en}, 0);
    chk("rst_resp", {s_axil_bresp, s_axil_rresp}, 0);
    chk("rst_rdata", s_axil_rdata, 0);
    chk("rst_wr_bus", {reg_wr_addr, reg_wr_data, reg_wr_strb}, 0);
    chk("rst_rd_addr", reg_rd_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue_write(16'h0013, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0, 0);
    wait_done(1);
    issue_write(16'h0042, 32'h12345678, 4'h3, 1, 2, 1, 0, 0);
    wait_done(1);
    issue_write(16'h0080, 32'h87654321, 4'hC, 2, 3, 0, 2, 1);
    wait_done(1);
    issue_read(16'h0104, 32'hDEADBEEF, 3, 0, 0);
    wait_done(0);
    issue_read(16'h0200, 32'h11111111, 0, 0, 1);
    wait_done(0);
    issue_read(16'h0208, 32'hCAFEF00D, 10, 10, 0);
    wait_done(0);
    issue_read(16'h020C, 32'h0F0F0F0F, TO - 1, 0, 0);
    wait_done(0);
    issue_read(16'h0210, 32'hF0F0F0F0, TO, 0, 0);
    wait_done(0);

    b_hold = 5;
    issue_write(16'h0300, 32'h55AA55AA, 4'h5, 0, 0, 0, 0, 0);
    wait_done(1);
    b_hold = 0;
    r_hold = 5;
    issue_read(16'h0304, 32'h13579BDF, 1, 0, 0);
    wait_done(0);
    r_hold = 0;

    fork
      begin
        issue_write(16'h0400, 32'hAAAA0000, 4'hF, 0, 0, 0, 0, 0);
        wait_done(1);
      end
      begin
        issue_read(16'h0404, 32'h0000BBBB, 0, 0, 0);
        wait_done(0);
      end
    join

    fork
      issue_write(16'h0500, 32'h0BAD0BAD, 4'hF, 0, 0, 0, 100, 1);
      issue_read(16'h0504, 32'h0, 0, 100, 1);
    join
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = reg_wr_en && reg_rd_en;
    end
    chk("pre_rst_en", {reg_wr_en, reg_rd_en}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_en", {reg_wr_en, reg_rd_en}, 0);
    chk("mid_rst_valid", {s_axil_bvalid, s_axil_rvalid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wr_exp_q.delete();
    rd_exp_q.delete();
    wr_plan_q.delete();
    rd_plan_q.delete();
    issue_write(16'h0600, 32'h600D600D, 4'hF, 0, 0, 2, 0, 0);
    wait_done(1);
    issue_read(16'h0604, 32'h600DF00D, 2, 1, 0);
    wait_done(0);

    fork
      repeat (120) rand_write();
      repeat (120) rand_read();
    join

    repeat (5) @(posedge clk);
    #1;
    chk("wr_exp_left", wr_exp_q.size(), 0);
    chk("rd_exp_left", rd_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
